// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
// Shared types and helpers for the iterative radix-2 Booth multiplier.
//   state_t      : control FSM states (IDLE, RUN)
//   booth_op_t   : decoded {Q[0], q_-1} pair
//   booth_iters  : number of Booth steps for a given operand width and mode
// ---------------------------------------------------------------------------
package booth_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Encoding is the raw {Q[0], q_-1} pair so a plain cast decodes it.
    typedef enum logic [1:0] {
        BOOTH_NOP0 = 2'b00,
        BOOTH_ADD  = 2'b01,
        BOOTH_SUB  = 2'b10,
        BOOTH_NOP1 = 2'b11
    } booth_op_t;

    // Signed operands already carry their sign in bit WIDTH-1; unsigned ones
    // need one more step so the zero extension bit is consumed as well.
    function automatic int booth_iters(input int width, input logic signed_mode);
        return signed_mode ? width : width + 1;
    endfunction

endpackage

// File: rtl/booth_step.sv
// ---------------------------------------------------------------------------
// booth_step
// One combinational radix-2 Booth step on the WIDTH+1 bit datapath:
// optional add/subtract of M into A, then arithmetic right shift of
// {A, Q, q_-1} by one bit. All arithmetic wraps modulo 2^(WIDTH+1).
// Ports:
//   i_a   [WIDTH:0]  accumulator A
//   i_q   [WIDTH:0]  multiplier register Q
//   i_qm1            q_-1 bit
//   i_m   [WIDTH:0]  extended multiplicand M
//   o_a   [WIDTH:0]  next A
//   o_q   [WIDTH:0]  next Q
//   o_qm1            next q_-1
// ---------------------------------------------------------------------------
module booth_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] i_a,
    input  logic [WIDTH:0] i_q,
    input  logic           i_qm1,
    input  logic [WIDTH:0] i_m,
    output logic [WIDTH:0] o_a,
    output logic [WIDTH:0] o_q,
    output logic           o_qm1
);
    import booth_pkg::*;

    booth_op_t      w_op;
    logic [WIDTH:0] w_sum;

    assign w_op = booth_op_t'({i_q[0], i_qm1});

    always_comb begin
        w_sum = i_a;
        case (w_op)
            BOOTH_ADD: w_sum = i_a + i_m;
            BOOTH_SUB: w_sum = i_a - i_m;
            default:   w_sum = i_a;
        endcase
    end

    // Arithmetic shift of the concatenated {A, Q, q_-1}.
    assign o_a   = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign o_q   = {w_sum[0], i_q[WIDTH:1]};
    assign o_qm1 = i_q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// ---------------------------------------------------------------------------
// booth_mult_seq
// Iterative radix-2 Booth multiplier, one multiplier bit per clock, with a
// start/done handshake. Signed (two's complement) or unsigned operands are
// selected per operation. Product is 2*WIDTH bits.
// Ports:
//   i_clk                       rising-edge clock
//   i_rst                       synchronous active-high reset
//   i_start                     request, sampled only while o_busy=0
//   i_signed_mode               1 = two's complement operands, 0 = unsigned
//   i_multiplicand [WIDTH-1:0]  operand M (captured with start)
//   i_multiplier   [WIDTH-1:0]  operand Q (captured with start)
//   o_busy                      operation in progress
//   o_done                      one-cycle pulse when o_product is updated
//   o_product  [2*WIDTH-1:0]    result, held until the next completion
// Optional build macro:
//   BOOTH_EARLY_TERM_EN  finish early once the remaining multiplier bits
//                        can no longer trigger an add/subtract.
// ---------------------------------------------------------------------------
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_signed_mode,
    input  logic [WIDTH-1:0]     i_multiplicand,
    input  logic [WIDTH-1:0]     i_multiplier,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);
    import booth_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 2);

    state_t               r_state;
    logic [WIDTH:0]       r_m;
    logic [WIDTH:0]       r_a;
    logic [WIDTH:0]       r_q;
    logic                 r_qm1;
    logic                 r_signed;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH:0]       w_ext_m;
    logic [WIDTH:0]       w_ext_q;
    logic [WIDTH:0]       w_step_a;
    logic [WIDTH:0]       w_step_q;
    logic                 w_step_qm1;
    logic                 w_early;
    logic [2*WIDTH+1:0]   w_shifted;

    // In signed mode only WIDTH steps run, so {A, Q} is still one bit short
    // of fully shifted; the product then sits one position higher.
    function automatic logic [2*WIDTH-1:0] take_product(
        input logic [2*WIDTH+1:0] full,
        input logic               sgn
    );
        return sgn ? full[2*WIDTH:1] : full[2*WIDTH-1:0];
    endfunction

    assign w_ext_m = i_signed_mode ? {i_multiplicand[WIDTH-1], i_multiplicand}
                                   : {1'b0, i_multiplicand};
    assign w_ext_q = i_signed_mode ? {i_multiplier[WIDTH-1], i_multiplier}
                                   : {1'b0, i_multiplier};

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_a   (r_a),
        .i_q   (r_q),
        .i_qm1 (r_qm1),
        .i_m   (r_m),
        .o_a   (w_step_a),
        .o_q   (w_step_q),
        .o_qm1 (w_step_qm1)
    );

`ifdef BOOTH_EARLY_TERM_EN
    // The unconsumed multiplier bits are r_q[r_cnt-1:0]. If they all equal
    // q_-1 every remaining pair is 00 or 11, so the rest of the operation is
    // pure shifting and can be collapsed into a single shift by r_cnt.
    always_comb begin
        w_early = 1'b1;
        for (int i = 0; i <= WIDTH; i++) begin
            if ((i < int'(r_cnt)) && (r_q[i] != r_qm1)) begin
                w_early = 1'b0;
            end
        end
        w_shifted = $signed({r_a, r_q}) >>> r_cnt;
    end
`else
    assign w_early   = 1'b0;
    assign w_shifted = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_m       <= '0;
            r_a       <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_signed  <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_m      <= w_ext_m;
                        r_a      <= '0;
                        r_q      <= w_ext_q;
                        r_qm1    <= 1'b0;
                        r_signed <= i_signed_mode;
                        r_cnt    <= CNT_W'(booth_iters(WIDTH, i_signed_mode));
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (w_early) begin
                        r_product <= take_product(w_shifted, r_signed);
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        r_a   <= w_step_a;
                        r_q   <= w_step_q;
                        r_qm1 <= w_step_qm1;
                        if (r_cnt == CNT_W'(1)) begin
                            r_product <= take_product({w_step_a, w_step_q}, r_signed);
                            r_done    <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= IDLE;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_product = r_product;

endmodule

// File: tb/tb_booth_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_booth_mult_seq
// Self-checking bench for booth_mult_seq at WIDTH=8: vector table, random
// operands against a native-multiply model, and hand-written sequences for
// mid-operation start, reset abort, back-to-back start and early termination.
// ---------------------------------------------------------------------------
module tb_booth_mult_seq;

    localparam int W = 8;

    logic          i_clk;
    logic          i_rst;
    logic          i_start;
    logic          i_signed_mode;
    logic [W-1:0]  i_multiplicand;
    logic [W-1:0]  i_multiplier;
    logic          o_busy;
    logic          o_done;
    logic [2*W-1:0] o_product;

    int total;
    int bad;
    int last_lat;
    logic [2*W-1:0] exp_q[$];

    typedef struct {
        string        name;
        logic         sgn;
        logic [W-1:0] m;
        logic [W-1:0] q;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[12];

    booth_mult_seq #(
        .WIDTH (W)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_signed_mode  (i_signed_mode),
        .i_multiplicand (i_multiplicand),
        .i_multiplier   (i_multiplier),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_product      (o_product)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [2*W-1:0] model(input logic sgn, input logic [W-1:0] m,
                                             input logic [W-1:0] q);
        logic signed [2*W-1:0] sp;
        logic [2*W-1:0]        up;
        sp = $signed(m) * $signed(q);
        up = {{W{1'b0}}, m} * {{W{1'b0}}, q};
        return sgn ? sp : up;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic wait_done(input int budget, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge i_clk);
            n++;
            if (o_done === 1'b1) seen = 1'b1;
        end
    endtask

    // Latency counts clock edges from the edge that samples start up to the
    // edge after which done is seen high.
    task automatic do_op(input string name, input logic sgn, input logic [W-1:0] m,
                         input logic [W-1:0] q, input logic [2*W-1:0] want);
        int n;
        bit seen;
        int nmax;
        logic [2*W-1:0] exp_p;
        exp_q.push_back(want);
        nmax           = sgn ? W + 1 : W + 2;
        i_signed_mode  = sgn;
        i_multiplicand = m;
        i_multiplier   = q;
        i_start        = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done(40, n, seen);
        last_lat = n + 1;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s timeout: no done within 40 cycles", name);
            exp_q.delete();
        end else begin
            exp_p = exp_q.pop_front();
            check({name, " product"}, o_product, exp_p);
            check({name, " busy at done"}, o_busy, 0);
`ifdef BOOTH_EARLY_TERM_EN
            check({name, " latency bound"}, last_lat <= nmax, 1);
`else
            check({name, " latency"}, last_lat, nmax);
`endif
        end
    endtask

    initial begin
        int n;
        bit seen;
        bit any_done;
        logic [2*W-1:0] exp_p;
        logic sg;
        logic [W-1:0] rm;
        logic [W-1:0] rq;

        total          = 0;
        bad            = 0;
        last_lat       = 0;
        i_rst          = 1'b1;
        i_start        = 1'b0;
        i_signed_mode  = 1'b0;
        i_multiplicand = '0;
        i_multiplier   = '0;

        vecs[0]  = '{"s 7*-3",      1'b1, 8'h07, 8'hFD, 16'hFFEB};
        vecs[1]  = '{"s -128*-128", 1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[2]  = '{"u 255*255",   1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[3]  = '{"u 0*0",       1'b0, 8'h00, 8'h00, 16'h0000};
        vecs[4]  = '{"s 127*-128",  1'b1, 8'h7F, 8'h80, 16'hC080};
        vecs[5]  = '{"u 200*3",     1'b0, 8'hC8, 8'h03, 16'h0258};
        vecs[6]  = '{"s -1*-1",     1'b1, 8'hFF, 8'hFF, 16'h0001};
        vecs[7]  = '{"s 5*0",       1'b1, 8'h05, 8'h00, 16'h0000};
        vecs[8]  = '{"s 5*-1",      1'b1, 8'h05, 8'hFF, 16'hFFFB};
        vecs[9]  = '{"u 128*2",     1'b0, 8'h80, 8'h02, 16'h0100};
        vecs[10] = '{"s 85*-86",    1'b1, 8'h55, 8'hAA, 16'hE372};
        vecs[11] = '{"u 170*85",    1'b0, 8'hAA, 8'h55, 16'h3872};

        repeat (3) @(negedge i_clk);
        check("reset busy", o_busy, 0);
        check("reset done", o_done, 0);
        check("reset product", o_product, 0);
        i_rst = 1'b0;
        @(negedge i_clk);

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].name, vecs[i].sgn, vecs[i].m, vecs[i].q, vecs[i].exp);
        end

        // Product holds while idle.
        repeat (5) @(negedge i_clk);
        check("hold product", o_product, 16'h3872);
        check("idle done low", o_done, 0);

        for (int i = 0; i < 8; i++) begin
            sg = 1'($urandom_range(0, 1));
            rm = 8'($urandom);
            rq = 8'($urandom);
            do_op($sformatf("rand%0d", i), sg, rm, rq, model(sg, rm, rq));
        end

        // Second start mid-operation is ignored.
        exp_q.push_back(16'h0253);
        i_signed_mode  = 1'b1;
        i_multiplicand = 8'h07;
        i_multiplier   = 8'h55;
        i_start        = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (3) @(negedge i_clk);
        i_start        = 1'b1;
        i_signed_mode  = 1'b0;
        i_multiplicand = 8'h11;
        i_multiplier   = 8'h22;
        @(negedge i_clk);
        check("midstart busy", o_busy, 1);
        i_start = 1'b0;
        wait_done(40, n, seen);
        check("midstart done seen", seen, 1);
        exp_p = exp_q.pop_front();
        check("midstart product", o_product, exp_p);
        check("midstart latency", n + 5, 9);
        @(negedge i_clk);
        check("midstart no extra done", o_done, 0);
        check("midstart idle", o_busy, 0);

        // Reset during RUN cycle 4 aborts the operation.
        exp_q.push_back(model(1'b0, 8'h64, 8'h55));
        i_signed_mode  = 1'b0;
        i_multiplicand = 8'h64;
        i_multiplier   = 8'h55;
        i_start        = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (3) @(negedge i_clk);
        check("pre-reset busy", o_busy, 1);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        exp_q.delete();
        check("abort busy", o_busy, 0);
        check("abort done", o_done, 0);
        check("abort product", o_product, 0);
        any_done = 1'b0;
        repeat (12) begin
            @(negedge i_clk);
            if (o_done === 1'b1) any_done = 1'b1;
        end
        check("no done after abort", any_done, 0);
        do_op("after reset", 1'b1, 8'h07, 8'hFD, 16'hFFEB);

        // start held high across done: back-to-back operations.
        exp_q.push_back(16'd132);
        i_signed_mode  = 1'b0;
        i_multiplicand = 8'd12;
        i_multiplier   = 8'd11;
        i_start        = 1'b1;
        wait_done(40, n, seen);
        check("b2b first seen", seen, 1);
        check("b2b first latency", n, 10);
        exp_p = exp_q.pop_front();
        check("b2b first product", o_product, exp_p);
        exp_q.push_back(16'hFFC1);
        i_signed_mode  = 1'b1;
        i_multiplicand = 8'hF9;
        i_multiplier   = 8'h09;
        @(negedge i_clk);
        check("b2b done single pulse", o_done, 0);
        check("b2b second accepted", o_busy, 1);
        i_start = 1'b0;
        wait_done(40, n, seen);
        check("b2b second seen", seen, 1);
        check("b2b second latency", n + 1, 9);
        exp_p = exp_q.pop_front();
        check("b2b second product", o_product, exp_p);
        @(negedge i_clk);
        check("b2b second single pulse", o_done, 0);

        // Early-termination corner operands.
        do_op("s 5*0 q0", 1'b1, 8'h05, 8'h00, 16'h0000);
`ifdef BOOTH_EARLY_TERM_EN
        check("early q0 latency", last_lat, 2);
`endif
        do_op("s 5*-1 qm1", 1'b1, 8'h05, 8'hFF, 16'hFFFB);
`ifdef BOOTH_EARLY_TERM_EN
        check("early qm1 latency short", last_lat < 9, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Iterative radix-2 Booth multiplier, parametrised in operand width; successor to the team's combinational 4-bit Booth unit.
- Processes one multiplier bit per clock under a start/done handshake.
- A mode input selects signed (two's complement) or unsigned operands.
- Sits in the datapath as a shared, low-area multiply resource feeding MAC/accumulate logic.

Parameters:
- WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+2), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only when busy=0.
- signed_mode  input  1  1 = operands two's complement, 0 = unsigned; captured with start.
- multiplicand  input  WIDTH  operand M; captured with start.
- multiplier  input  WIDTH  operand Q; captured with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when product is updated.
- product  output  2*WIDTH  result, held until the next completion.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, product=0, all internal registers cleared. Reset mid-operation aborts; no done is produced for the aborted operation.
- FSM states:
  - IDLE: on start=1, capture operands and mode, load the accumulator and counter, go to RUN, busy=1 from the next cycle.
  - RUN: one Booth step per cycle; when the count is exhausted, go to IDLE.
- Internal width: WIDTH+1 bits throughout.
  - Operands are extended to WIDTH+1 bits: sign-extended if signed_mode=1, zero-extended if 0.
  - Accumulator A is WIDTH+1 bits; Q register is WIDTH+1 bits; q_-1 is 1 bit.
- Iterations: N = WIDTH if signed_mode=1, N = WIDTH+1 if signed_mode=0.
- Step rule on {Q[0], q_-1}:
  - 10: A = A - M.
  - 01: A = A + M.
  - 00 or 11: no change.
  - After the add/subtract, arithmetic right shift of {A, Q, q_-1} by 1.
  - All add/subtract is modulo 2^(WIDTH+1).
- Product: the low 2*WIDTH bits of {A, Q} after N steps (signed mode compensates the extra extension bit).
- Completion: product is registered at the edge ending the last step. done=1 and busy=0 in the following cycle.
- Latency: start-sampled edge to done-high is N+1 cycles.
- Throughput: one operation per N+1 cycles.
- start is ignored while busy=1; operand and mode inputs are don't-care while busy.
- start=1 in the same cycle as done=1 is accepted; done is not extended.
- done never asserts without a prior accepted start.
- Operand extremes: most-negative × most-negative in signed mode yields a positive product. No overflow is possible at 2*WIDTH bits.

Optional Feature:
- Macro: BOOTH_EARLY_TERM_EN.
- Defined:
  - Before each RUN step, if all not-yet-consumed Q bits and q_-1 are equal, no further add/subtract can occur.
  - In that cycle, the block applies one arithmetic right shift by the remaining count, registers the product, and completes.
  - Minimum latency: start edge to done = 2 cycles (e.g. multiplier=0).
  - The result is identical to the non-terminated path.
- Undefined: fixed latency of N+1 cycles always; no barrel shifter is instantiated.

Decomposition:
- Shared package booth_pkg:
  - FSM state enum (IDLE, RUN).
  - Booth pair encodings (BOOTH_NOP0, BOOTH_ADD, BOOTH_SUB, BOOTH_NOP1).
  - A function computing N from WIDTH and mode.
- One natural sub-module: booth_step.
  - Combinational add/sub plus arithmetic shift of {A, Q, q_-1}.
  - Parametrised by WIDTH.
  - Instantiated once and reused every cycle.

Test Plan:
- WIDTH=8, signed, M=7, Q=-3 -> done after 9 cycles, product=16'hFFEB (-21).
- WIDTH=8, signed, M=-128, Q=-128 -> product=16'h4000; unsigned, M=255, Q=255 -> product=16'hFE01 after 10 cycles.
- Second start pulsed mid-operation with different operands -> ignored; first result is delivered; busy stays high until completion.
- rst asserted on RUN cycle 4 -> next cycle busy=0, done=0, product=0; a new start completes correctly.
- start held high across done -> back-to-back operations; exactly one done pulse per operation; product updates each time.
- With BOOTH_EARLY_TERM_EN defined, signed, Q=0, M=5 -> done 2 cycles after start, product=0; Q=-1, M=5 -> product=16'hFFFB, latency below 9 cycles.
